// File: rtl/ram_access_responder.sv
// ram_access_responder: block-RAM stand-in for the SDRAM controller request interface with controller-like timing
module ram_access_responder #(
   parameter int ADDR_WIDTH       = 16,
   parameter int INIT_CYCLES      = 8,
   parameter int READ_LATENCY     = 2,
   parameter int RECOVER_CYCLES   = 1,
   parameter int REFRESH_INTERVAL = 780,
   parameter int REFRESH_CYCLES   = 4
) (
   input  logic        sdram_clock,
   input  logic        reset_n,
   input  logic [24:0] address,
   input  logic [9:0]  access_num,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   input  logic        write_request,
   input  logic        read_request,
   input  logic        ldqm,
   input  logic        udqm,
   output logic        write_flag,
   output logic        read_flag,
   output logic        idle
);
   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_REFRESH, S_WRITE, S_READ_WAIT, S_READ, S_RECOVER
   } state_t;

   state_t                r_state;
   logic [15:0]           r_mem [0:(1<<ADDR_WIDTH)-1];
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_cnt;
   logic [31:0]           r_len;
   logic [31:0]           r_ref_cnt;
   logic                  r_ref_pend;
   logic                  r_idle;
   logic                  r_wflag;
   logic                  r_rflag;
   logic [15:0]           r_dout;
   logic [31:0]           w_len;
   logic                  w_ref_hit;
   logic                  w_unused;

   assign w_len     = (access_num == 10'd0) ? 32'd1 : {22'd0, access_num};
   assign w_ref_hit = (REFRESH_INTERVAL != 0) && (r_state != S_INIT) &&
                      (r_ref_cnt == 32'(REFRESH_INTERVAL - 1));
   assign w_unused  = ^address[24:ADDR_WIDTH];
   assign data_out   = r_dout;
   assign write_flag = r_wflag;
   assign read_flag  = r_rflag;
   assign idle       = r_idle;

   // Byte-masked store of data_in at the current burst word on every WRITE-state edge
   always_ff @(posedge sdram_clock) begin
      if (r_state == S_WRITE && !ldqm) r_mem[r_addr][7:0]  <= data_in[7:0];
      if (r_state == S_WRITE && !udqm) r_mem[r_addr][15:8] <= data_in[15:8];
   end

   // Free-running refresh interval counter, held at zero until initialisation completes
   always_ff @(posedge sdram_clock or negedge reset_n) begin
      if (!reset_n) r_ref_cnt <= '0;
      else if (REFRESH_INTERVAL != 0 && r_state != S_INIT) r_ref_cnt <= w_ref_hit ? '0 : r_ref_cnt + 32'd1;
   end

   // Access sequencer: init delay, request arbitration, bursts, recovery and refresh stalls
   always_ff @(posedge sdram_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_INIT;
         r_cnt      <= '0;
         r_len      <= '0;
         r_addr     <= '0;
         r_ref_pend <= 1'b0;
         r_idle     <= 1'b0;
         r_wflag    <= 1'b0;
         r_rflag    <= 1'b0;
         r_dout     <= '0;
      end else begin
         r_cnt <= r_cnt + 32'd1;
         case (r_state)
            S_INIT: begin
               if (r_cnt == 32'(INIT_CYCLES - 1)) begin
                  r_state <= S_IDLE;
                  r_idle  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            S_IDLE: begin
               r_cnt <= '0;
               if (r_ref_pend) begin
                  r_state    <= S_REFRESH;
                  r_ref_pend <= 1'b0;
                  r_idle     <= 1'b0;
               end else if (write_request) begin
                  r_state <= S_WRITE;
                  r_wflag <= 1'b1;
                  r_idle  <= 1'b0;
                  r_addr  <= address[ADDR_WIDTH-1:0];
                  r_len   <= w_len;
               end else if (read_request) begin
                  r_state <= S_READ_WAIT;
                  r_idle  <= 1'b0;
                  r_addr  <= address[ADDR_WIDTH-1:0];
                  r_len   <= w_len;
               end
            end
            S_REFRESH: begin
               if (r_cnt == 32'(REFRESH_CYCLES - 1)) begin
                  r_state <= S_IDLE;
                  r_idle  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            S_WRITE: begin
               r_addr <= r_addr + 1'b1;
               if (r_cnt == r_len - 32'd1) begin
                  r_state <= S_RECOVER;
                  r_wflag <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            S_READ_WAIT: begin
               if (r_cnt == 32'(READ_LATENCY - 1)) begin
                  r_state <= S_READ;
                  r_rflag <= 1'b1;
                  r_dout  <= r_mem[r_addr];
                  r_addr  <= r_addr + 1'b1;
                  r_cnt   <= '0;
               end
            end
            S_READ: begin
               if (r_cnt == r_len - 32'd1) begin
                  r_state <= S_RECOVER;
                  r_rflag <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_dout <= r_mem[r_addr];
                  r_addr <= r_addr + 1'b1;
               end
            end
            S_RECOVER: begin
               if (r_cnt == 32'(RECOVER_CYCLES - 1)) begin
                  r_state <= S_IDLE;
                  r_idle  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            default: r_state <= S_INIT;
         endcase
         if (w_ref_hit) r_ref_pend <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ram_access_responder.sv
// tb_ram_access_responder: directed stimulus with a timeline model of the responder checked every cycle
module tb_ram_access_responder;
   localparam int INIT = 8;
   localparam int LAT  = 2;
   localparam int REC  = 1;
   localparam int RI   = 16;
   localparam int RC   = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [24:0] address = '0;
   logic [9:0]  access_num = '0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;
   logic        write_request = 1'b0;
   logic        read_request = 1'b0;
   logic        ldqm = 1'b0;
   logic        udqm = 1'b0;
   logic        write_flag;
   logic        read_flag;
   logic        idle;

   int checks = 0;
   int errors = 0;

   ram_access_responder #(
      .ADDR_WIDTH(16), .INIT_CYCLES(INIT), .READ_LATENCY(LAT),
      .RECOVER_CYCLES(REC), .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
   ) dut (
      .sdram_clock(clk), .reset_n(rst_n), .address(address), .access_num(access_num),
      .data_in(data_in), .data_out(data_out), .write_request(write_request),
      .read_request(read_request), .ldqm(ldqm), .udqm(udqm),
      .write_flag(write_flag), .read_flag(read_flag), .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Timeline model: edges since reset, the edge from which the block is idle, and burst windows
   int          e, ready, ws, wn, rs, rn;
   bit          pend;
   logic [15:0] wbase, rbase;
   bit   [15:0] mmem [0:65535];
   logic        m_idle, m_wf, m_rf;
   logic [15:0] m_do;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e = 0; ready = INIT; pend = 0; ws = -100; wn = 0; rs = -100; rn = 0;
         wbase = '0; rbase = '0;
         m_idle = 0; m_wf = 0; m_rf = 0; m_do = '0;
      end else begin
         logic [15:0] a;
         int len;
         e++;
         if (e > ws && e <= ws + wn) begin
            a = wbase + 16'(e - ws - 1);
            if (!ldqm) mmem[a][7:0]  = data_in[7:0];
            if (!udqm) mmem[a][15:8] = data_in[15:8];
         end
         len = (access_num == 0) ? 1 : int'(access_num);
         if (e > ready) begin
            if (pend) begin
               pend = 0; ready = e + RC;
            end else if (write_request) begin
               ws = e; wn = len; wbase = address[15:0]; ready = e + len + REC;
            end else if (read_request) begin
               rs = e; rn = len; rbase = address[15:0]; ready = e + LAT + len + REC;
            end
         end
         if (e > INIT && (e - INIT) % RI == 0) pend = 1;
         m_idle = (e >= ready);
         m_wf   = (e >= ws && e < ws + wn);
         m_rf   = (e >= rs + LAT && e < rs + LAT + rn);
         if (m_rf) m_do = mmem[rbase + 16'(e - rs - LAT)];
      end
   end

   // Every cycle, away from the active edge, the outputs must match the model
   always @(negedge clk) begin
      check("idle", idle, m_idle);
      check("write_flag", write_flag, m_wf);
      check("read_flag", read_flag, m_rf);
      check("data_out", data_out, m_do);
   end

   logic [15:0] wdata [0:31];
   logic [15:0] rdata [0:31];
   int wi, ri;

   task automatic start(input bit wr, input bit rd, input logic [24:0] a, input logic [9:0] n,
                        input bit lq, input bit uq);
      @(negedge clk);
      address = a; access_num = n; ldqm = lq; udqm = uq;
      write_request = wr; read_request = rd; wi = 0; ri = 0;
   endtask

   // Serve one burst: feed write data, capture read data, count flags and idle-low lead-in
   task automatic burst(output int nw, output int nr, output int lowrun);
      int low;
      low = 0; nw = 0; nr = 0; lowrun = -1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (write_flag || read_flag) begin
            if (nw + nr == 0) lowrun = low;
            if (write_flag) begin write_request = 0; data_in = wdata[wi]; wi++; nw++; end
            if (read_flag) begin read_request = 0; rdata[ri] = data_out; ri++; nr++; end
         end else if (nw + nr > 0) begin
            return;
         end else begin
            low = idle ? 0 : low + 1;
         end
      end
      check("burst_timeout", 1, 0);
   endtask

   task automatic wait_init(input string nm);
      int n, fl;
      n = 0; fl = 0;
      while (!idle && n < 50) begin
         @(posedge clk); #1;
         n++;
         if (write_flag || read_flag) fl = 1;
      end
      check(nm, n, INIT);
      check({nm, "_flags"}, fl, 0);
   endtask

   initial begin
      int nw, nr, lr, c, low, fl;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      wait_init("init_cycles");

      wdata[0] = 16'h0000;
      start(1, 0, 25'h0010, 10'd1, 0, 0); burst(nw, nr, lr);
      wdata[0] = 16'h12AB;
      start(1, 0, 25'h0010, 10'd1, 0, 1); burst(nw, nr, lr);
      check("masked_wr_pulse", nw, 1);
      check("masked_wr_lead", lr, 0);
      start(0, 1, 25'h0010, 10'd1, 0, 0); burst(nw, nr, lr);
      check("masked_rd_pulse", nr, 1);
      check("masked_rd_latency", lr, LAT);
      check("masked_rd_data", rdata[0], 16'h00AB);

      wdata[0] = 16'h1111; wdata[1] = 16'h2222;
      start(1, 1, 25'h0020, 10'd2, 0, 0); burst(nw, nr, lr);
      check("both_req_write", nw, 2);
      check("both_req_no_read", nr, 0);
      burst(nw, nr, lr);
      check("both_req_read_len", nr, 2);
      check("both_req_read_lat", lr, LAT);
      check("both_req_d0", rdata[0], 16'h1111);
      check("both_req_d1", rdata[1], 16'h2222);

      for (int k = 0; k < 4; k++) wdata[k] = 16'(k + 1);
      start(1, 0, 25'h0FFFE, 10'd4, 0, 0); burst(nw, nr, lr);
      check("wrap_wr_len", nw, 4);
      start(0, 1, 25'h0FFFE, 10'd4, 0, 0); burst(nw, nr, lr);
      check("wrap_rd_len", nr, 4);
      for (int k = 0; k < 4; k++) check($sformatf("wrap_rd%0d", k), rdata[k], 32'(k + 1));
      start(0, 1, 25'h0000, 10'd2, 0, 0); burst(nw, nr, lr);
      check("wrap_low0", rdata[0], 16'h0003);
      check("wrap_low1", rdata[1], 16'h0004);

      for (int k = 0; k < 20; k++) wdata[k] = 16'hA000 + 16'(k);
      start(1, 1, 25'h0100, 10'd20, 0, 0); burst(nw, nr, lr);
      check("refresh_wr_len", nw, 20);
      c = 0; while (!idle && c < 100) begin @(negedge clk); c++; end
      c = 0; while (idle && c < 100) begin @(negedge clk); c++; end
      low = 0; fl = 0; c = 0;
      while (!idle && c < 100) begin
         if (read_flag || write_flag) fl = 1;
         low++;
         @(negedge clk);
         c++;
      end
      check("refresh_stall_len", low, RC);
      check("refresh_stall_flags", fl, 0);
      ri = 0; burst(nw, nr, lr);
      check("refresh_rd_len", nr, 20);
      for (int k = 0; k < 20; k++) check($sformatf("refresh_rd%0d", k), rdata[k], 32'(16'hA000 + k));

      start(0, 1, 25'h0FFFE, 10'd4, 0, 0);
      c = 0; nr = 0;
      while (nr < 2 && c < 100) begin
         @(negedge clk);
         if (read_flag) nr++;
         c++;
      end
      check("reset_reached_2nd", nr, 2);
      #1 rst_n = 0; read_request = 0;
      #1;
      check("reset_rflag", read_flag, 0);
      check("reset_idle", idle, 0);
      check("reset_dout", data_out, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      wait_init("reinit_cycles");
      start(0, 1, 25'h0FFFE, 10'd4, 0, 0); burst(nw, nr, lr);
      check("post_reset_len", nr, 4);
      for (int k = 0; k < 4; k++) check($sformatf("post_reset_rd%0d", k), rdata[k], 32'(k + 1));
      start(0, 1, 25'h0010, 10'd0, 0, 0); burst(nw, nr, lr);
      check("zero_len_is_one", nr, 1);
      check("zero_len_data", rdata[0], 16'h00AB);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
